// File: rtl/prog_load_dump_ctrl.sv
// Program loader / run supervisor / result dumper for a pipelined CPU.
// Streams words into imem, runs the CPU until halt or timeout, then streams dmem out.
module prog_load_dump_ctrl #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 32,
  parameter int MAX_CYCLES = 100000,
  parameter int HALT_GRACE = 2,
  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1,
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_data,
  input  logic           in_last,
  output logic           imem_we,
  output logic [IAW-1:0] imem_addr,
  output logic [31:0]    imem_wdata,
  output logic           cpu_reset,
  input  logic [31:0]    cpu_instruction,
  output logic [DAW-1:0] dmem_rd_addr,
  input  logic [63:0]    dmem_rd_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [63:0]    out_data,
  output logic           out_last,
  output logic [31:0]    cycle_count,
  output logic           timeout,
  output logic           done
);

  typedef enum logic [2:0] {
    S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [IAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DAW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           to_q, to_d;
  logic [63:0]    odata_q, odata_d;
  logic           halt;
  logic           rd_last;

  assign imem_addr    = wr_ptr_q;
  assign imem_wdata   = in_data;
  assign dmem_rd_addr = rd_ptr_q;
  assign out_data     = odata_q;
  assign cycle_count  = cnt_q;
  assign timeout      = to_q;

  // Zero fetches are ignored during the first HALT_GRACE cycles while the pipeline fills.
  assign halt    = (cpu_instruction == 32'd0) && (cnt_q >= 32'(HALT_GRACE));
  assign rd_last = (rd_ptr_q == DAW'(DMEM_DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      to_q     <= 1'b0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      odata_q  <= odata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    odata_d   = odata_q;
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    cpu_reset = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_LOAD: begin
        cpu_reset = 1'b1;
        in_ready  = 1'b1;
        if (in_valid) begin
          imem_we  = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (in_last || (wr_ptr_q == IAW'(IMEM_DEPTH - 1))) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        // The exiting cycle is counted as well; halt wins over a coincident timeout.
        cnt_d = cnt_q + 32'd1;
        if (halt) begin
          state_d = S_DUMP_RD;
        end else if (cnt_q == 32'(MAX_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = S_DUMP_RD;
        end
      end
      S_DUMP_RD: begin
        odata_d = dmem_rd_data;
        state_d = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        out_valid = 1'b1;
        out_last  = rd_last;
        if (out_ready) begin
          if (rd_last) begin
            state_d = S_DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = S_DUMP_RD;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase
  end

endmodule

// File: tb/tb_prog_load_dump_ctrl.sv
// Randomized self-checking bench for prog_load_dump_ctrl: load, run/halt/timeout, dump, reset abort.
module tb_prog_load_dump_ctrl;
  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 32;
  localparam int MAX_CYCLES = 50;
  localparam int HALT_GRACE = 2;
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready, in_last;
  logic [31:0]    in_data;
  logic           imem_we;
  logic [IAW-1:0] imem_addr;
  logic [31:0]    imem_wdata;
  logic           cpu_reset;
  logic [31:0]    cpu_instruction;
  logic [DAW-1:0] dmem_rd_addr;
  logic [63:0]    dmem_rd_data;
  logic           out_valid, out_ready, out_last;
  logic [63:0]    out_data;
  logic [31:0]    cycle_count;
  logic           timeout, done;

  logic [63:0] dmem [DMEM_DEPTH];
  int checks = 0;
  int failures = 0;
  logic [31:0] g_cnt;
  bit          g_to;

  always #5 clk = ~clk;
  assign dmem_rd_data = dmem[dmem_rd_addr];

  prog_load_dump_ctrl #(
    .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH),
    .MAX_CYCLES(MAX_CYCLES), .HALT_GRACE(HALT_GRACE)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_instruction(cpu_instruction),
    .dmem_rd_addr(dmem_rd_addr), .dmem_rd_data(dmem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .cycle_count(cycle_count), .timeout(timeout), .done(done)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fill_dmem(input bit random_data);
    for (int i = 0; i < DMEM_DEPTH; i++)
      dmem[i] = random_data ? {$urandom, $urandom} : 64'(i * 3);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; cpu_instruction = 32'h0000_0013;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
    out_ready = 1'b1; cpu_instruction = '0;
    step(); step();
    in_valid = 1'b0; #1;
    checks++;
    if ({in_ready, cpu_reset, imem_we, out_valid, out_last, timeout, done} !== 7'b1100000)
      $display("FAIL reset_ctrl got=%b want=1100000",
               {in_ready, cpu_reset, imem_we, out_valid, out_last, timeout, done});
    if ({in_ready, cpu_reset, imem_we, out_valid, out_last, timeout, done} !== 7'b1100000) failures++;
    checks++;
    if (out_data !== 64'd0 || cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_data out_data=%h cycle_count=%0d want 0/0", out_data, cycle_count);
    end
    reset = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_load in_ready=%b cpu_reset=%b done=%b want 1/1/0", in_ready, cpu_reset, done);
    end
  endtask

  // Feeds words with random idle gaps; checks each transfer hits the next imem address.
  task automatic load_words(input logic [31:0] w[$], input bit use_last);
    int bad = 0;
    for (int i = 0; i < w.size(); i++) begin
      if ($urandom_range(3) == 0) begin
        in_valid = 1'b0; in_data = $urandom; #1;
        if (imem_we !== 1'b0 || in_ready !== 1'b1) bad++;
        step();
      end
      in_valid = 1'b1; in_data = w[i]; in_last = use_last && (i == w.size() - 1); #1;
      if ({in_ready, imem_we, imem_addr, imem_wdata} !== {1'b1, 1'b1, IAW'(i), w[i]}) begin
        bad++;
        $display("FAIL load_word idx=%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 i, imem_we, imem_addr, imem_wdata, i, w[i]);
      end
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL load_stream bad_cycles=%0d want 0", bad);
    end
    checks++;
    if (in_ready !== 1'b0 || cpu_reset !== 1'b0) begin
      failures++;
      $display("FAIL run_entry in_ready=%b cpu_reset=%b want 0/0", in_ready, cpu_reset);
    end
  endtask

  // Reference: exit at first zero fetch at or after the grace window, else at MAX_CYCLES-1.
  task automatic run_cpu(input logic [31:0] sched[$]);
    int exit_k = -1;
    int bad = 0;
    for (int k = 0; k < MAX_CYCLES; k++)
      if (exit_k < 0 && sched[k] == 32'd0 && k >= HALT_GRACE) exit_k = k;
    g_to = (exit_k < 0);
    if (g_to) exit_k = MAX_CYCLES - 1;
    g_cnt = 32'(exit_k + 1);
    for (int k = 0; k <= exit_k; k++) begin
      cpu_instruction = sched[k]; #1;
      if (cycle_count !== 32'(k) || cpu_reset !== 1'b0 || timeout !== 1'b0 || out_valid !== 1'b0) bad++;
      step();
    end
    cpu_instruction = $urandom;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL run_track bad_cycles=%0d want 0", bad);
    end
    checks++;
    if (cycle_count !== g_cnt || timeout !== g_to) begin
      failures++;
      $display("FAIL run_exit cycle_count=%0d timeout=%b want %0d/%b", cycle_count, timeout, g_cnt, g_to);
    end
    checks++;
    if (out_valid !== 1'b0 || cpu_reset !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL dump_entry out_valid=%b cpu_reset=%b in_ready=%b want 0/0/0", out_valid, cpu_reset, in_ready);
    end
  endtask

  // Consumes the dump stream; abort_beat >= 0 asserts reset while that beat is offered.
  task automatic dump(input int ready_pct, input int abort_beat);
    int beat = 0;
    int cyc = 0;
    int last_acc = -100;
    bit holding = 0;
    logic [63:0] held = '0;
    while (beat < DMEM_DEPTH && cyc < 4000) begin
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (out_valid === 1'b1) begin
        if (beat == abort_beat) begin
          reset = 1'b1; #1;
          checks++;
          if ({in_ready, cpu_reset, imem_we, out_valid, out_last, timeout, done} !== 7'b1100000 ||
              out_data !== 64'd0 || cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL abort_reset ctrl=%b out_data=%h cycle_count=%0d want 1100000/0/0",
                     {in_ready, cpu_reset, imem_we, out_valid, out_last, timeout, done}, out_data, cycle_count);
          end
          step();
          checks++;
          if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_hold out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
          end
          reset = 1'b0; out_ready = 1'b0;
          return;
        end
        if (holding) begin
          checks++;
          if (out_data !== held) begin
            failures++;
            $display("FAIL beat_stable beat=%0d got=%h want=%h", beat, out_data, held);
          end
        end
        checks++;
        if (out_data !== dmem[beat] || out_last !== (beat == DMEM_DEPTH - 1)) begin
          failures++;
          $display("FAIL beat_data beat=%0d got=%h last=%b want=%h last=%b",
                   beat, out_data, out_last, dmem[beat], beat == DMEM_DEPTH - 1);
        end
        if (out_ready) begin
          if (ready_pct >= 100 && beat > 0) begin
            checks++;
            if (cyc - last_acc != 2) begin
              failures++;
              $display("FAIL beat_spacing beat=%0d got=%0d want=2", beat, cyc - last_acc);
            end
          end
          last_acc = cyc; beat++; holding = 0;
        end else begin
          holding = 1; held = out_data;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (beat != DMEM_DEPTH) begin
      failures++;
      $display("FAIL dump_budget beats=%0d want=%0d", beat, DMEM_DEPTH);
    end
  endtask

  task automatic check_done();
    int bad = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'($urandom_range(1)); in_data = $urandom; in_last = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1)); cpu_instruction = $urandom_range(1) ? 32'd0 : $urandom;
      #1;
      if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || imem_we !== 1'b0 ||
          cpu_reset !== 1'b0 || cycle_count !== g_cnt || timeout !== g_to) bad++;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL done_state bad_cycles=%0d want 0 (done=%b cycle_count=%0d want %0d)", bad, done, cycle_count, g_cnt);
    end
  endtask

  task automatic test_halt_program();
    logic [31:0] prog[$];
    logic [31:0] sched[$];
    do_reset();
    fill_dmem(0);
    prog = '{32'h0030_0093, 32'h0000_0000};
    load_words(prog, 1);
    // Fetch model: word k on cycle k, zero once past the end of the program.
    for (int k = 0; k < MAX_CYCLES; k++) sched.push_back(k < prog.size() ? prog[k] : 32'd0);
    run_cpu(sched);
    dump(100, -1);
    check_done();
  endtask

  task automatic test_random_runs();
    for (int it = 0; it < 4; it++) begin
      logic [31:0] prog[$];
      logic [31:0] sched[$];
      int n = $urandom_range(1, 12);
      do_reset();
      fill_dmem(1);
      for (int i = 0; i < n; i++) prog.push_back($urandom);
      load_words(prog, 1);
      for (int k = 0; k < MAX_CYCLES; k++)
        sched.push_back(($urandom_range(11) == 0) ? 32'd0 : ($urandom | 32'd1));
      run_cpu(sched);
      dump(50, -1);
      check_done();
    end
  endtask

  task automatic test_halt_timeout_tie();
    logic [31:0] prog[$];
    logic [31:0] sched[$];
    do_reset();
    fill_dmem(1);
    prog = '{32'h0000_006f};
    load_words(prog, 1);
    for (int k = 0; k < MAX_CYCLES; k++) sched.push_back(k == MAX_CYCLES - 1 ? 32'd0 : 32'h0000_006f);
    run_cpu(sched);
    dump(70, -1);
    check_done();
  endtask

  task automatic test_overflow_timeout_abort();
    logic [31:0] prog[$];
    logic [31:0] sched[$];
    do_reset();
    fill_dmem(1);
    for (int i = 0; i < IMEM_DEPTH; i++) prog.push_back($urandom);
    load_words(prog, 0);
    in_valid = 1'b1; in_data = $urandom; #1;
    checks++;
    if (imem_we !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL overflow_reject imem_we=%b in_ready=%b want 0/0", imem_we, in_ready);
    end
    in_valid = 1'b0;
    for (int k = 0; k < MAX_CYCLES; k++) sched.push_back(32'h0000_006f);
    run_cpu(sched);
    dump(100, 5);
    step();
    checks++;
    if (cpu_reset !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL post_abort cpu_reset=%b in_ready=%b out_valid=%b cycle_count=%0d want 1/1/0/0",
               cpu_reset, in_ready, out_valid, cycle_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; cpu_instruction = '0;
    fill_dmem(0);
    test_reset();
    test_halt_program();
    test_random_runs();
    test_halt_timeout_tie();
    test_overflow_timeout_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_load_dump_ctrl.md
PROG_LOAD_DUMP_CTRL -- requirements
Module: prog_load_dump_ctrl

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, 256: instruction-memory words loadable.
REQ-002 SHALL have parameter DMEM_DEPTH, 32: data-memory doublewords dumped.
REQ-003 SHALL have parameter MAX_CYCLES, 100000: run timeout in cycles.
REQ-004 SHALL have parameter HALT_GRACE, 2: RUN cycles during which halt detection is ignored.
REQ-005 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1: asynchronous, active-high.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_data input 32, in_last input 1: program word stream.
REQ-008 SHALL have ports imem_we output 1, imem_addr output $clog2(IMEM_DEPTH), imem_wdata output 32: instruction-memory write port.
REQ-009 SHALL have port cpu_reset  output  1: holds the pipelined CPU in reset.
REQ-010 SHALL have port cpu_instruction  input  32: instruction currently fetched by the CPU.
REQ-011 SHALL have ports dmem_rd_addr output $clog2(DMEM_DEPTH), dmem_rd_data input 64: data-memory read port with combinational, same-cycle read.
REQ-012 SHALL have ports out_valid output 1, out_ready input 1, out_data output 64, out_last output 1: result dump stream.
REQ-013 SHALL have ports cycle_count output 32, timeout output 1, done output 1.

Function
REQ-014 SHALL implement states LOAD, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-015 LOAD SHALL drive cpu_reset=1 and in_ready=1; all other states SHALL drive in_ready=0.
REQ-016 In LOAD, an in_valid&in_ready cycle SHALL pulse imem_we for that cycle, with imem_addr=wr_ptr and imem_wdata=in_data, then increment wr_ptr.
REQ-017 A transfer with in_last=1, or a transfer at wr_ptr=IMEM_DEPTH-1, SHALL move LOAD->RUN on the next edge; words beyond are never accepted.
REQ-018 RUN SHALL drive cpu_reset=0 and increment cycle_count by 1 every cycle; cycle_count SHALL be 0 on RUN entry.
REQ-019 In RUN, cpu_instruction==0 with cycle_count>=HALT_GRACE SHALL move RUN->DUMP_RD; that cycle SHALL still be counted.
REQ-020 In RUN, cycle_count reaching MAX_CYCLES-1 SHALL set timeout=1 and move RUN->DUMP_RD; halt and timeout in the same cycle SHALL count as halt (timeout=0).
REQ-021 cycle_count SHALL freeze on leaving RUN and hold until reset.
REQ-022 cpu_reset SHALL remain 0 in DUMP_RD, DUMP_OUT and DONE.
REQ-023 DUMP_RD SHALL drive dmem_rd_addr=rd_ptr, register dmem_rd_data into out_data, and move to DUMP_OUT.
REQ-024 DUMP_OUT SHALL hold out_valid=1 with out_data stable until out_ready=1.
REQ-025 out_last SHALL equal (rd_ptr==DMEM_DEPTH-1) while out_valid=1.
REQ-026 On out_valid&out_ready in DUMP_OUT: if out_last=1 the block SHALL move to DONE; otherwise it SHALL increment rd_ptr and move to DUMP_RD. Peak throughput is 1 word per 2 cycles.
REQ-027 DONE SHALL assert done=1 and out_valid=0, ignore all inputs, and persist until reset.
REQ-028 out_valid SHALL never be asserted outside DUMP_OUT; imem_we SHALL never be asserted outside LOAD.

Reset
REQ-029 Asserting reset SHALL immediately force: state=LOAD, cpu_reset=1, in_ready=1, imem_we=0, out_valid=0, out_last=0, out_data=0, wr_ptr=0, rd_ptr=0, cycle_count=0, timeout=0, done=0.
REQ-030 Reset asserted mid-LOAD, RUN or DUMP SHALL abort the operation without emitting a partial stream beat; memory contents are not cleared by this block.
REQ-031 Deassertion SHALL take effect on the first rising clk edge after reset falls.

Verification
REQ-032 Load 2 words (0x00300093, then 0x00000000 with in_last) -> imem[0..1] written, RUN entered; halt after fetch of word 1; cycle_count equals the number of RUN cycles up to and including the halt cycle; timeout=0.
REQ-033 Dump with out_ready=1 constantly, dmem[i]=i*3 -> 32 beats out_data=0,3,...,93, each 2 cycles apart; out_last only on beat 31; then done=1.
REQ-034 Dump with out_ready toggled randomly -> no beat lost or duplicated; out_data stable while out_valid&!out_ready.
REQ-035 MAX_CYCLES=50 with a self-loop program (no zero fetch) -> RUN exits after 50 counted cycles, cycle_count=50, timeout=1, dump still completes.
REQ-036 Stream 256 words without in_last -> 256th word forces RUN, in_ready=0 afterwards; reset asserted during beat 5 of the dump -> outputs return to reset values immediately.
